debouncer: RTL
==============

DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 500000, meaning the number of consecutive equal synchronized samples needed to accept a level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning btn_raw is pressed when 0 (1) or pressed when 1 (0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port btn_raw, input, 1 bit: asynchronous, bouncing push-button or switch level.
REQ-006 The block SHALL have port db_level, output, 1 bit: debounced level, active-high, 1 = pressed; drives the downstream one-shot input.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-008 The block SHALL normalize btn_raw to n = btn_raw XOR ACTIVE_LOW, so that n = 1 means pressed.
REQ-009 The block SHALL pass n through a two-flop synchronizer; s is the second flop output, and only s is used by the FSM.
REQ-010 The block SHALL implement a 4-state FSM: REL_STABLE, PRESS_WAIT, PRS_STABLE, REL_WAIT.
REQ-011 The block SHALL implement the counter cnt with width $clog2(STABLE_CYCLES)+1 bits, unsigned, never wrapping.
REQ-012 In REL_STABLE: if s = 1, the block SHALL go to PRESS_WAIT with cnt = 1; otherwise it SHALL stay, with cnt = 0.
REQ-013 In PRESS_WAIT: if s = 0, the block SHALL return to REL_STABLE with cnt = 0; if s = 1 and cnt = STABLE_CYCLES-1, it SHALL go to PRS_STABLE with cnt = 0; otherwise it SHALL increment cnt.
REQ-014 In PRS_STABLE: if s = 0, the block SHALL go to REL_WAIT with cnt = 1; otherwise it SHALL stay, with cnt = 0.
REQ-015 In REL_WAIT: if s = 1, the block SHALL return to PRS_STABLE with cnt = 0; if s = 0 and cnt = STABLE_CYCLES-1, it SHALL go to REL_STABLE with cnt = 0; otherwise it SHALL increment cnt.
REQ-016 The block SHALL drive db_level as a registered Moore output: 1 in PRS_STABLE and REL_WAIT, 0 in REL_STABLE and PRESS_WAIT.
REQ-017 The block SHALL drive busy as a registered Moore output: 1 in PRESS_WAIT and REL_WAIT, else 0.
REQ-018 Latency SHALL be exactly STABLE_CYCLES+2 clock edges from the first edge sampling a clean new btn_raw level to the db_level change; busy SHALL be high for STABLE_CYCLES-1 cycles before it.
REQ-019 Any opposite sample of s during a WAIT state SHALL abort qualification, with no db_level change; the next qualification restarts from cnt = 1.
REQ-020 Pulses on s shorter than STABLE_CYCLES cycles SHALL never change db_level.
REQ-021 Elaboration SHALL fail if STABLE_CYCLES < 2 or STABLE_CYCLES > 2**24.
REQ-022 db_level SHALL never toggle more than once per STABLE_CYCLES cycles.

Reset
REQ-023 With rst = 1 at a clock edge, the block SHALL set both synchronizer flops to 0, the state to REL_STABLE, cnt = 0, db_level = 0 and busy = 0.
REQ-024 Reset SHALL take priority over all transitions, including mid-qualification and in PRS_STABLE; outputs SHALL be 0 on the first edge with rst = 1.
REQ-025 If the button is held pressed through reset, the block SHALL treat it as a new press after release and qualify it with the full STABLE_CYCLES+2 latency.

Verification (STABLE_CYCLES = 4 unless noted)
REQ-026 ACTIVE_LOW = 0, rst = 1 for 3 cycles, btn_raw = 1 throughout -> outputs 0 during reset; busy = 1 after edges 3-5 post-release; db_level = 1 from edge 6.
REQ-027 ACTIVE_LOW = 0, btn_raw 0->1 held 10 cycles, then 1->0 held 10 cycles -> db_level rises at edge 6 after the rise; db_level falls at edge 6 after the fall; busy high for 3 cycles before each change.
REQ-028 Glitch: btn_raw = 1 for 3 cycles, then 0 -> db_level stays 0; busy high for 3 cycles then 0; state ends in REL_STABLE.
REQ-029 Bounce: btn_raw pattern 1,1,0,1,0,1,1,1,1,1 -> db_level rises exactly 6 edges after the final 0->1 transition.
REQ-030 Reset mid-PRESS_WAIT (cnt = 2), and separately reset in PRS_STABLE -> busy = 0 and db_level = 0 after that edge; a held button requalifies in 6 edges.
REQ-031 ACTIVE_LOW = 1, btn_raw 1->0 held 10 cycles -> db_level = 1 at edge 6; btn_raw back to 1 -> db_level = 0 at edge 6.

Source files
------------

// File: rtl/debouncer.sv
// Push-button / switch debouncer.
// The raw level is normalised to "1 = pressed", brought into the clock
// domain by a two-flop synchronizer, and accepted only after it has stayed
// at the new value for STABLE_CYCLES consecutive synchronized samples.
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic db_level,
  output logic busy
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Reject qualification windows that are too short to debounce or too wide for the counter.
  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 32'd16777216) begin : g_bad_stable_cycles
      $error("debouncer: STABLE_CYCLES must be in [2, 2**24]");
    end
  endgenerate

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS_STABLE = 2'd2,
    REL_WAIT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             db_level_q, db_level_d;
  logic             busy_q, busy_d;
  logic             norm_c;

  assign norm_c = btn_raw ^ ACTIVE_LOW;

  // Two-flop synchronizer on the normalised (1 = pressed) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= norm_c;
      sync2_q <= sync1_q;
    end
  end

  // State, qualification counter and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REL_STABLE;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: a change must hold for STABLE_CYCLES samples; any opposite sample aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      REL_STABLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = REL_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS_STABLE: begin
        if (!sync2_q) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (sync2_q) begin
          state_d = PRS_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL_STABLE;
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    db_level_d = (state_d == PRS_STABLE) || (state_d == REL_WAIT);
    busy_d     = (state_d == PRESS_WAIT) || (state_d == REL_WAIT);
  end

  assign db_level = db_level_q;
  assign busy     = busy_q;

endmodule
